// File: rtl/bcd_conv_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_conv_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } stateT;

   localparam logic [3:0] BCD_CORR_THRESH = 4'd5;
   localparam logic [3:0] BCD_CORR_ADD    = 4'd3;

   // Add-3 correction for one BCD digit, applied ahead of each shift.
   function automatic logic [3:0] dabbleCorrect(input logic [3:0] digit);
      return (digit >= BCD_CORR_THRESH) ? 4'(digit + BCD_CORR_ADD) : digit;
   endfunction

endpackage

// File: rtl/bcd_conv_seq_dabble_digit.sv
// One BCD digit of the double-dabble correction stage (purely combinational).
module dabble_digit
   import bcd_conv_seq_pkg::*;
(
   input  logic [3:0] digitIn,
   output logic [3:0] digitOut_c
);

   always_comb begin
      digitOut_c = dabbleCorrect(digitIn);
   end

endmodule

// File: rtl/bcd_conv_seq.sv
// Multi-cycle double-dabble sequencer: one correct+shift step per clock,
// start/done handshake, result held stable between conversions.
module bcd_conv_seq
   import bcd_conv_seq_pkg::*;
#(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  overflow
);

   localparam int unsigned BCD_W  = 4 * DIGITS;
   localparam int unsigned STEP_W = $clog2(WIDTH + 1);

   stateT               state, stateNext;
   logic [STEP_W-1:0]   step, stepNext;
   logic [BCD_W-1:0]    bcdWork, bcdWorkNext;
   logic [WIDTH-1:0]    binShift, binShiftNext;
   logic                ovfWork, ovfWorkNext;
   logic [BCD_W-1:0]    bcdOutNext;
   logic                overflowNext;
   logic                busyNext, doneNext;
   logic [BCD_W-1:0]    corrWork_c;
   logic                accept_c;

   for (genvar g = 0; g < DIGITS; g++) begin : gDigit
      dabble_digit uDigit (
         .digitIn    (bcdWork[4*g +: 4]),
         .digitOut_c (corrWork_c[4*g +: 4])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         step     <= '0;
         bcdWork  <= '0;
         binShift <= '0;
         ovfWork  <= 1'b0;
         bcd_out  <= '0;
         overflow <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= stateNext;
         step     <= stepNext;
         bcdWork  <= bcdWorkNext;
         binShift <= binShiftNext;
         ovfWork  <= ovfWorkNext;
         bcd_out  <= bcdOutNext;
         overflow <= overflowNext;
         busy     <= busyNext;
         done     <= doneNext;
      end
   end

   // Next-state, datapath step and output-register load.
   always_comb begin
      stateNext    = state;
      stepNext     = step;
      bcdWorkNext  = bcdWork;
      binShiftNext = binShift;
      ovfWorkNext  = ovfWork;
      bcdOutNext   = bcd_out;
      overflowNext = overflow;
      accept_c     = 1'b0;

      case (state)
         ST_IDLE: begin
            if (start) accept_c = 1'b1;
         end
         ST_SHIFT: begin
            // Bit leaving the top digit is lost, so it marks overflow.
            bcdWorkNext  = {corrWork_c[BCD_W-2:0], binShift[WIDTH-1]};
            binShiftNext = {binShift[WIDTH-2:0], 1'b0};
            ovfWorkNext  = ovfWork | corrWork_c[BCD_W-1];
            stepNext     = step + STEP_W'(1);
            if (step == STEP_W'(WIDTH - 1)) begin
               stateNext    = ST_DONE;
               bcdOutNext   = bcdWorkNext;
               overflowNext = ovfWorkNext;
            end
         end
         ST_DONE: begin
            if (start) accept_c = 1'b1;
            else       stateNext = ST_IDLE;
         end
         default: begin
            stateNext = ST_IDLE;
         end
      endcase

      if (accept_c) begin
         stateNext    = ST_SHIFT;
         stepNext     = '0;
         bcdWorkNext  = '0;
         binShiftNext = bin_in;
         ovfWorkNext  = 1'b0;
      end

      busyNext = (stateNext == ST_SHIFT);
      doneNext = (stateNext == ST_DONE);
   end

endmodule

// File: tb/tb_bcd_conv_seq.sv
// Directed bench for bcd_conv_seq: a 3-digit and a 2-digit instance on one clock.
module tb_bcd_conv_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start3, start2;
   logic [7:0]  bin3, bin2;
   logic        busy3, done3, ovf3;
   logic        busy2, done2, ovf2;
   logic [11:0] bcd3;
   logic [7:0]  bcd2;

   int nVec = 0;
   int nErr = 0;

   always #5 clk = ~clk;

   bcd_conv_seq #(.WIDTH(8), .DIGITS(3)) uDut3 (
      .clk(clk), .rst(rst), .start(start3), .bin_in(bin3),
      .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(ovf3)
   );

   bcd_conv_seq #(.WIDTH(8), .DIGITS(2)) uDut2 (
      .clk(clk), .rst(rst), .start(start2), .bin_in(bin2),
      .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2)
   );

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nVec++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one conversion on the 3-digit unit; optionally pulse start during cycles lo..hi.
   task automatic runConv3(input string tag, input logic [7:0] val, input logic [11:0] exp,
                           input int lo, input int hi);
      int n;
      int busyCnt;
      logic [11:0] held;
      start3 = 1'b1;
      bin3   = val;
      tick();
      start3 = 1'b0;
      bin3   = ~val;
      n = 1;
      busyCnt = 0;
      while (!done3 && n < 20) begin
         if (busy3) busyCnt++;
         start3 = (n >= lo && n <= hi);
         tick();
         n++;
      end
      start3 = 1'b0;
      checkEq({tag, "_latency"}, 32'(n), 32'd9);
      checkEq({tag, "_busycnt"}, 32'(busyCnt), 32'd8);
      checkEq({tag, "_bcd"}, 32'(bcd3), 32'(exp));
      checkEq({tag, "_ovf"}, 32'(ovf3), 32'd0);
      held = bcd3;
      tick();
      checkEq({tag, "_donepulse"}, 32'(done3), 32'd0);
      checkEq({tag, "_hold"}, 32'(bcd3), 32'(exp));
      checkEq({tag, "_hold_eq"}, 32'(bcd3), 32'(held));
   endtask

   task automatic runConv2(input string tag, input logic [7:0] val, input logic [7:0] exp,
                           input logic expOvf);
      int n;
      start2 = 1'b1;
      bin2   = val;
      tick();
      start2 = 1'b0;
      n = 1;
      while (!done2 && n < 20) begin
         tick();
         n++;
      end
      checkEq({tag, "_latency"}, 32'(n), 32'd9);
      checkEq({tag, "_bcd"}, 32'(bcd2), 32'(exp));
      checkEq({tag, "_ovf"}, 32'(ovf2), 32'(expOvf));
      tick();
   endtask

   initial begin
      int firstDone;
      int secondDone;
      int doneCnt;
      logic [11:0] res1, res2;

      rst = 1'b1; start3 = 1'b0; start2 = 1'b0; bin3 = '0; bin2 = '0;
      tick(); tick();
      checkEq("rst_busy", 32'(busy3), 32'd0);
      checkEq("rst_done", 32'(done3), 32'd0);
      checkEq("rst_bcd", 32'(bcd3), 32'd0);
      checkEq("rst_ovf", 32'(ovf3), 32'd0);
      rst = 1'b0;
      tick();

      // T1, T2
      runConv3("t1_255", 8'd255, 12'h255, 0, -1);
      runConv3("t2_0",   8'd0,   12'h000, 0, -1);
      runConv3("t2_99",  8'd99,  12'h099, 0, -1);
      runConv3("t2_200", 8'd200, 12'h200, 0, -1);
      // T3: start pulses during SHIFT ignored
      runConv3("t3_42",  8'd42,  12'h042, 3, 7);
      repeat (12) begin
         checkEq("t3_no_extra_done", 32'(done3), 32'd0);
         tick();
      end

      // T4: reset mid-conversion
      start3 = 1'b1; bin3 = 8'd255;
      tick();
      start3 = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      tick();
      checkEq("t4_busy", 32'(busy3), 32'd0);
      checkEq("t4_done", 32'(done3), 32'd0);
      checkEq("t4_bcd", 32'(bcd3), 32'd0);
      rst = 1'b0;
      doneCnt = 0;
      repeat (14) begin
         if (done3 || busy3) doneCnt++;
         tick();
      end
      checkEq("t4_no_done", 32'(doneCnt), 32'd0);

      // rst and start together: rst wins
      rst = 1'b1; start3 = 1'b1; bin3 = 8'd7;
      tick();
      checkEq("rst_wins_busy", 32'(busy3), 32'd0);
      rst = 1'b0; start3 = 1'b0;
      tick();

      // T5: start held high, back-to-back
      start3 = 1'b1; bin3 = 8'd17;
      tick();
      bin3 = 8'd18;
      firstDone = -1; secondDone = -1; doneCnt = 0; res1 = '0; res2 = '0;
      for (int n = 1; n < 30; n++) begin
         if (done3) begin
            doneCnt++;
            if (firstDone < 0) begin
               firstDone = n; res1 = bcd3;
            end else if (secondDone < 0) begin
               secondDone = n; res2 = bcd3;
            end
         end
         if (firstDone >= 0 && n > firstDone) start3 = 1'b0;
         tick();
      end
      start3 = 1'b0;
      checkEq("t5_done_cnt", 32'(doneCnt), 32'd2);
      checkEq("t5_first_at", 32'(firstDone), 32'd9);
      checkEq("t5_spacing", 32'(secondDone - firstDone), 32'd9);
      checkEq("t5_res1", 32'(res1), 32'h017);
      checkEq("t5_res2", 32'(res2), 32'h018);

      // T6: two-digit instance, overflow boundary
      runConv2("t6_100", 8'd100, 8'h00, 1'b1);
      runConv2("t6_99",  8'd99,  8'h99, 1'b0);
      runConv2("t6_255", 8'd255, 8'h55, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
